// File: rtl/multi_core_data_mem.sv
// Multi-lane data memory: processor row port plus host load/dump stream engine.
// Optional build macro DMEM_WR_FWD_EN selects write-first processor reads (default read-first).
module multi_core_data_mem #(
   parameter int REG_WIDTH           = 12,
   parameter int CORE_COUNT          = 4,
   parameter int DATA_MEM_ADDR_WIDTH = 12
) (
   input  logic                                clk,
   input  logic                                rstN,
   input  logic [DATA_MEM_ADDR_WIDTH-1:0]      dataMemAddr,
   input  logic                                DataMemWrEn,
   input  logic [REG_WIDTH*CORE_COUNT-1:0]     ProcessorDataOut,
   output logic [REG_WIDTH*CORE_COUNT-1:0]     ProcessorDataIn,
   input  logic [1:0]                          hostCmd,
   input  logic [DATA_MEM_ADDR_WIDTH-1:0]      hostLen,
   input  logic                                hostValid,
   input  logic [REG_WIDTH-1:0]                hostData,
   output logic                                hostReady,
   output logic                                dumpValid,
   output logic [REG_WIDTH-1:0]                dumpData,
   input  logic                                dumpReady,
   output logic                                memBusy
);

   localparam int ROW_W  = REG_WIDTH * CORE_COUNT;
   localparam int DEPTH  = 2 ** DATA_MEM_ADDR_WIDTH;
   localparam int LANE_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
   localparam logic [LANE_W-1:0]              LANE_LAST = LANE_W'(CORE_COUNT - 1);
   localparam logic [LANE_W-1:0]              LANE_ONE  = LANE_W'(1);
   localparam logic [DATA_MEM_ADDR_WIDTH-1:0] ROW_ONE   = DATA_MEM_ADDR_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_LOAD     = 2'b01,
      ST_DUMP_RD  = 2'b10,
      ST_DUMP_OUT = 2'b11
   } state_e;

   state_e                         state_q, state_d;
   logic [DATA_MEM_ADDR_WIDTH-1:0] row_q, row_d;
   logic [DATA_MEM_ADDR_WIDTH-1:0] len_q, len_d;
   logic [LANE_W-1:0]              lane_q, lane_d;
   logic [ROW_W-1:0]               buf_q, buf_d;
   logic [ROW_W-1:0]               prd_q, prd_d;
   logic                           host_ready_q, host_ready_d;
   logic                           dump_valid_q, dump_valid_d;
   logic [REG_WIDTH-1:0]           dump_data_q, dump_data_d;
   logic                           busy_q, busy_d;

   logic [ROW_W-1:0]               mem_q [DEPTH];

   logic                           proc_wr_s, load_wr_s, dump_hs_s, last_row_s;
   logic [LANE_W-1:0]              lane_nxt_s;
   logic [ROW_W-1:0]               rd_row_s, dump_row_s;

   assign proc_wr_s  = (state_q == ST_IDLE) && DataMemWrEn;
   assign load_wr_s  = (state_q == ST_LOAD) && hostValid && host_ready_q;
   assign dump_hs_s  = (state_q == ST_DUMP_OUT) && dump_valid_q && dumpReady;
   assign last_row_s = (row_q == (len_q - ROW_ONE));
   assign lane_nxt_s = lane_q + LANE_ONE;
   assign rd_row_s   = mem_q[dataMemAddr];
   assign dump_row_s = mem_q[row_q];

   // Storage array: processor writes whole rows, the load stream writes one lane at a time.
   always_ff @(posedge clk) begin
      if (proc_wr_s) begin
         mem_q[dataMemAddr] <= ProcessorDataOut;
      end else if (load_wr_s) begin
         for (int l = 0; l < CORE_COUNT; l++) begin
            if (lane_q == LANE_W'(l)) begin
               mem_q[row_q][l*REG_WIDTH +: REG_WIDTH] <= hostData;
            end
         end
      end
   end

   // Next-state logic for the host engine and all registered outputs.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      len_d       = len_q;
      lane_d      = lane_q;
      buf_d       = buf_q;
      prd_d       = prd_q;
      dump_data_d = dump_data_q;

      case (state_q)
         ST_IDLE: begin
`ifdef DMEM_WR_FWD_EN
            prd_d = DataMemWrEn ? ProcessorDataOut : rd_row_s;
`else
            prd_d = rd_row_s;
`endif
            if ((hostCmd == 2'b01) && (hostLen != '0)) begin
               state_d = ST_LOAD;
               row_d   = '0;
               lane_d  = '0;
               len_d   = hostLen;
            end else if ((hostCmd == 2'b10) && (hostLen != '0)) begin
               state_d = ST_DUMP_RD;
               row_d   = '0;
               lane_d  = '0;
               len_d   = hostLen;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (load_wr_s) begin
               if (lane_q == LANE_LAST) begin
                  lane_d = '0;
                  if (last_row_s) begin
                     state_d = ST_IDLE;
                  end else begin
                     row_d = row_q + ROW_ONE;
                  end
               end else begin
                  lane_d = lane_nxt_s;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_DUMP_RD: begin
            buf_d       = dump_row_s;
            dump_data_d = dump_row_s[REG_WIDTH-1:0];
            lane_d      = '0;
            state_d     = ST_DUMP_OUT;
         end
         ST_DUMP_OUT: begin
            if (dump_hs_s) begin
               if (lane_q == LANE_LAST) begin
                  lane_d = '0;
                  if (last_row_s) begin
                     state_d = ST_IDLE;
                  end else begin
                     row_d   = row_q + ROW_ONE;
                     state_d = ST_DUMP_RD;
                  end
               end else begin
                  lane_d = lane_nxt_s;
                  // Pre-select the following lane so dumpData is valid the cycle after the handshake.
                  for (int l = 0; l < CORE_COUNT; l++) begin
                     if (lane_nxt_s == LANE_W'(l)) begin
                        dump_data_d = buf_q[l*REG_WIDTH +: REG_WIDTH];
                     end
                  end
               end
            end else begin
               state_d = ST_DUMP_OUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      host_ready_d = (state_d == ST_LOAD);
      dump_valid_d = (state_d == ST_DUMP_OUT);
      busy_d       = (state_d != ST_IDLE);
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q      <= ST_IDLE;
         row_q        <= '0;
         len_q        <= '0;
         lane_q       <= '0;
         buf_q        <= '0;
         prd_q        <= '0;
         host_ready_q <= 1'b0;
         dump_valid_q <= 1'b0;
         dump_data_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         len_q        <= len_d;
         lane_q       <= lane_d;
         buf_q        <= buf_d;
         prd_q        <= prd_d;
         host_ready_q <= host_ready_d;
         dump_valid_q <= dump_valid_d;
         dump_data_q  <= dump_data_d;
         busy_q       <= busy_d;
      end
   end

   assign ProcessorDataIn = prd_q;
   assign hostReady       = host_ready_q;
   assign dumpValid       = dump_valid_q;
   assign dumpData        = dump_data_q;
   assign memBusy         = busy_q;

endmodule

// File: tb/tb_multi_core_data_mem.sv
// Directed self-checking bench for multi_core_data_mem (default config 12-bit lanes, 4 cores).
module tb_multi_core_data_mem;

   logic          clk;
   logic          rstN;
   logic [11:0]   dataMemAddr;
   logic          DataMemWrEn;
   logic [47:0]   ProcessorDataOut;
   logic [47:0]   ProcessorDataIn;
   logic [1:0]    hostCmd;
   logic [11:0]   hostLen;
   logic          hostValid;
   logic [11:0]   hostData;
   logic          hostReady;
   logic          dumpValid;
   logic [11:0]   dumpData;
   logic          dumpReady;
   logic          memBusy;

   int tests_run;
   int tests_failed;

   multi_core_data_mem #(
      .REG_WIDTH(12), .CORE_COUNT(4), .DATA_MEM_ADDR_WIDTH(12)
   ) dut (
      .clk(clk), .rstN(rstN), .dataMemAddr(dataMemAddr), .DataMemWrEn(DataMemWrEn),
      .ProcessorDataOut(ProcessorDataOut), .ProcessorDataIn(ProcessorDataIn),
      .hostCmd(hostCmd), .hostLen(hostLen), .hostValid(hostValid), .hostData(hostData),
      .hostReady(hostReady), .dumpValid(dumpValid), .dumpData(dumpData),
      .dumpReady(dumpReady), .memBusy(memBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle so outputs reflect that edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [11:0] dump_exp [4];
   int          idx;
   logic [47:0] wr_exp;

   initial begin
      tests_run = 0; tests_failed = 0;
      rstN = 1'b0; dataMemAddr = 12'h000; DataMemWrEn = 1'b0; ProcessorDataOut = 48'h0;
      hostCmd = 2'b00; hostLen = 12'h000; hostValid = 1'b0; hostData = 12'h000; dumpReady = 1'b0;
      tick(); tick();
      check_eq("rst_prd",   64'(ProcessorDataIn), 64'h0);
      check_eq("rst_ready", 64'(hostReady), 64'h0);
      check_eq("rst_dval",  64'(dumpValid), 64'h0);
      check_eq("rst_ddata", 64'(dumpData), 64'h0);
      check_eq("rst_busy",  64'(memBusy), 64'h0);
      rstN = 1'b1;
      tick();

      // Reset in the middle of a load: three lanes of row 0 written, then abort.
      hostCmd = 2'b01; hostLen = 12'd2; hostValid = 1'b1; hostData = 12'h101;
      tick();
      hostCmd = 2'b00;
      check_eq("t1_ready", 64'(hostReady), 64'h1);
      check_eq("t1_busy",  64'(memBusy), 64'h1);
      tick(); hostData = 12'h102;
      tick(); hostData = 12'h103;
      tick();
      hostValid = 1'b0;
      rstN = 1'b0;
      #1;
      check_eq("t1_rst_ready", 64'(hostReady), 64'h0);
      check_eq("t1_rst_busy",  64'(memBusy), 64'h0);
      check_eq("t1_rst_prd",   64'(ProcessorDataIn), 64'h0);
      check_eq("t1_rst_dval",  64'(dumpValid), 64'h0);
      tick();
      rstN = 1'b1;
      dataMemAddr = 12'h000;
      tick();
      check_eq("t1_row0_kept", 64'(ProcessorDataIn[35:0]), 64'h1031_0210_1);
      check_eq("t1_idle_busy", 64'(memBusy), 64'h0);

      // Full two-row load; processor writes during the load must be dropped, late hostLen ignored.
      hostCmd = 2'b01; hostLen = 12'd2;
      tick();
      hostCmd = 2'b00; hostLen = 12'd5;
      DataMemWrEn = 1'b1; dataMemAddr = 12'h001; ProcessorDataOut = 48'hEEEEEEEEEEEE;
      for (int i = 0; i < 8; i++) begin
         hostValid = 1'b1;
         hostData  = 12'(i + 1);
         tick();
      end
      hostValid = 1'b0; DataMemWrEn = 1'b0;
      check_eq("t2_ready_low", 64'(hostReady), 64'h0);
      check_eq("t2_busy_low",  64'(memBusy), 64'h0);
      dataMemAddr = 12'h001;
      tick();
      check_eq("t2_row1", 64'(ProcessorDataIn), 64'h0000_0080_0700_6005);
      dataMemAddr = 12'h000;
      tick();
      check_eq("t2_row0", 64'(ProcessorDataIn), 64'h0000_0040_0300_2001);

      // Processor write of row 0, then dump it with dumpReady toggling every cycle.
      DataMemWrEn = 1'b1; dataMemAddr = 12'h000; ProcessorDataOut = 48'hDDDCCCBBBAAA;
      tick();
      DataMemWrEn = 1'b0;
      dump_exp[0] = 12'hAAA; dump_exp[1] = 12'hBBB; dump_exp[2] = 12'hCCC; dump_exp[3] = 12'hDDD;
      hostCmd = 2'b10; hostLen = 12'd1;
      tick();
      hostCmd = 2'b00;
      check_eq("t3_busy", 64'(memBusy), 64'h1);
      check_eq("t3_rd_dval", 64'(dumpValid), 64'h0);
      idx = 0;
      for (int c = 0; c < 40 && idx < 4; c++) begin
         dumpReady = c[0];
         if (dumpValid) begin
            check_eq($sformatf("t3_ddata%0d", idx), 64'(dumpData), 64'(dump_exp[idx]));
            if (dumpReady) idx++;
         end
         tick();
      end
      dumpReady = 1'b0;
      check_eq("t3_words", 64'(idx), 64'd4);
      check_eq("t3_end_dval", 64'(dumpValid), 64'h0);
      check_eq("t3_end_busy", 64'(memBusy), 64'h0);

      // Same-cycle write and read of row 5.
      DataMemWrEn = 1'b1; dataMemAddr = 12'h005; ProcessorDataOut = 48'h0;
      tick();
      ProcessorDataOut = 48'h123123123123;
      tick();
      DataMemWrEn = 1'b0;
`ifdef DMEM_WR_FWD_EN
      wr_exp = 48'h123123123123;
`else
      wr_exp = 48'h000000000000;
`endif
      check_eq("t4_same_cycle", 64'(ProcessorDataIn), 64'(wr_exp));
      tick();
      check_eq("t4_after", 64'(ProcessorDataIn), 64'h0000_1231_2312_3123);

      // Commands that must leave the engine idle.
      hostCmd = 2'b11; hostLen = 12'd3;
      tick();
      check_eq("t5_cmd11_busy",  64'(memBusy), 64'h0);
      check_eq("t5_cmd11_ready", 64'(hostReady), 64'h0);
      hostCmd = 2'b01; hostLen = 12'd0;
      tick();
      check_eq("t5_load0_busy",  64'(memBusy), 64'h0);
      check_eq("t5_load0_ready", 64'(hostReady), 64'h0);
      hostCmd = 2'b10; hostLen = 12'd0;
      tick();
      hostCmd = 2'b00;
      check_eq("t5_dump0_busy", 64'(memBusy), 64'h0);
      check_eq("t5_dump0_dval", 64'(dumpValid), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
